// File: rtl/store_buffer.sv
// Word-granular store buffer between the MEM-stage store-merge logic and the
// data-memory write port. Entries drain in order over valid/ready. A store to
// the same word as the youngest entry is merged into that entry, and loads can
// be forwarded the youngest matching word.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    output logic             st_ready,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit,
    output logic [31:0]      ld_data,
    output logic             mem_valid,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_data,
    input  logic             mem_ready,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] valid_q;
    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;

    logic             push;
    logic             pop;
    logic             coalesce;
    logic             alloc;
    logic [PTR_W-1:0] young_idx;

    // Byte-offset bits are irrelevant for word-granular storage and lookup.
    logic unused_byte_bits;
    assign unused_byte_bits = ^{st_addr[1:0], ld_addr[1:0]};

    // Handshakes and the merge-vs-allocate decision for the incoming store.
    always_comb begin
        young_idx = tail_q - PTR_W'(1);
        push      = st_valid && (count_q != FullCount);
        pop       = mem_ready && (count_q != '0);
        // The youngest entry cannot absorb the store if it is leaving this cycle.
        coalesce  = push && (count_q != '0) && (addr_q[young_idx] == st_addr[31:2]) &&
                    !((young_idx == head_q) && pop);
        alloc     = push && !coalesce;
    end

    // Status and drain-port outputs, taken from registered state only.
    always_comb begin
        st_ready  = (count_q != FullCount);
        empty     = (count_q == '0);
        mem_valid = (count_q != '0);
        count     = count_q;
        mem_addr  = mem_valid ? {addr_q[head_q], 2'b00} : 32'h0;
        mem_data  = mem_valid ? data_q[head_q] : 32'h0;
    end

    // Forwarding lookup: walk from youngest to oldest, first word match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        ld_hit  = 1'b0;
        ld_data = 32'h0;
        idx     = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = tail_q - PTR_W'(i + 1);
            if (!ld_hit && valid_q[idx] && (addr_q[idx] == ld_addr[31:2])) begin
                ld_hit  = 1'b1;
                ld_data = data_q[idx];
            end
        end
    end

    // Entry array, pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            if (coalesce) begin
                data_q[young_idx] <= st_data;
            end
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= st_addr[31:2];
                data_q[tail_q]  <= st_data;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (alloc && !pop) begin
                count_q <= count_q + (PTR_W + 1)'(1);
            end else if (pop && !alloc) begin
                count_q <= count_q - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue-based model of the buffer is
// compared against the DUT every cycle, plus literal expectations per scenario.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             st_valid = 1'b0;
    logic [31:0]      st_addr = '0;
    logic [31:0]      st_data = '0;
    logic             st_ready;
    logic [31:0]      ld_addr = '0;
    logic             ld_hit;
    logic [31:0]      ld_data;
    logic             mem_valid;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_data;
    logic             mem_ready = 1'b0;
    logic             empty;
    logic [PTR_W:0]   count;

    int checks = 0;
    int failures = 0;

    store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .ld_data   (ld_data),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .empty     (empty),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an ordered list of buffered words, oldest at index 0.
    logic [29:0] m_addr[$];
    logic [31:0] m_data[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_addr.delete();
            m_data.delete();
        end else begin
            int  n;
            bit  do_push;
            bit  do_pop;
            bit  merge;
            n       = m_addr.size();
            do_push = st_valid && (n < DEPTH);
            do_pop  = mem_ready && (n > 0);
            merge   = do_push && (n > 0) && (m_addr[n-1] == st_addr[31:2]) &&
                      !(n == 1 && do_pop);
            if (merge) m_data[n-1] = st_data;
            if (do_pop) begin
                void'(m_addr.pop_front());
                void'(m_data.pop_front());
            end
            if (do_push && !merge) begin
                m_addr.push_back(st_addr[31:2]);
                m_data.push_back(st_data);
            end
        end
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clk) begin
        int          n;
        logic        e_hit;
        logic [31:0] e_ld;
        n     = m_addr.size();
        e_hit = 1'b0;
        e_ld  = 32'h0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!e_hit && m_addr[i] == ld_addr[31:2]) begin
                e_hit = 1'b1;
                e_ld  = m_data[i];
            end
        end
        chk("m_count", 32'(count), 32'(n));
        chk("m_empty", 32'(empty), 32'(n == 0));
        chk("m_st_ready", 32'(st_ready), 32'(n < DEPTH));
        chk("m_mem_valid", 32'(mem_valid), 32'(n > 0));
        chk("m_mem_addr", mem_addr, (n > 0) ? {m_addr[0], 2'b00} : 32'h0);
        chk("m_mem_data", mem_data, (n > 0) ? m_data[0] : 32'h0);
        chk("m_ld_hit", 32'(ld_hit), 32'(e_hit));
        chk("m_ld_data", ld_data, e_ld);
    end

    // Drive one cycle of inputs, returning just after the clock edge.
    task automatic cyc(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic mr, input logic [31:0] la);
        st_valid  = sv;
        st_addr   = sa;
        st_data   = sd;
        mem_ready = mr;
        ld_addr   = la;
        @(posedge clk);
        #1;
    endtask

    // Idle inputs with a chosen lookup address, then wait to mid-cycle.
    task automatic look(input logic [31:0] la);
        st_valid  = 1'b0;
        mem_ready = 1'b0;
        ld_addr   = la;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // 1: reset and idle
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        look(32'h0);
        chk("rst_st_ready", 32'(st_ready), 32'h1);
        chk("rst_mem_valid", 32'(mem_valid), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_ld_hit", 32'(ld_hit), 32'h0);

        // 2: single push, forwarding with a non-zero byte offset
        cyc(1, 32'h100, 32'hAAAA_0001, 0, 0);
        look(32'h102);
        chk("t2_count", 32'(count), 32'h1);
        chk("t2_mem_valid", 32'(mem_valid), 32'h1);
        chk("t2_mem_addr", mem_addr, 32'h100);
        chk("t2_mem_data", mem_data, 32'hAAAA_0001);
        chk("t2_ld_hit", 32'(ld_hit), 32'h1);
        chk("t2_ld_data", ld_data, 32'hAAAA_0001);
        cyc(0, 0, 0, 1, 0);

        // 3: coalescing into youngest only
        cyc(1, 32'h104, 32'h11, 0, 0);
        cyc(1, 32'h106, 32'h22, 0, 0);
        look(32'h104);
        chk("t3_count1", 32'(count), 32'h1);
        chk("t3_data22", ld_data, 32'h22);
        cyc(1, 32'h108, 32'h44, 0, 0);
        cyc(1, 32'h104, 32'h33, 0, 0);
        look(32'h104);
        chk("t3_count3", 32'(count), 32'h3);
        chk("t3_ld33", ld_data, 32'h33);
        chk("t3_head_old", mem_data, 32'h22);
        repeat (3) cyc(0, 0, 0, 1, 0);
        // Sole entry leaving this cycle: same-word store must allocate anew.
        cyc(1, 32'h200, 32'h1, 0, 0);
        cyc(1, 32'h200, 32'h2, 1, 0);
        look(32'h200);
        chk("t3_nomerge_count", 32'(count), 32'h1);
        chk("t3_nomerge_data", mem_data, 32'h2);
        cyc(0, 0, 0, 1, 0);

        // 4: fill, drop while full, drain in order
        for (int i = 0; i < 4; i++) cyc(1, 32'(4 * i), 32'hC0 + 32'(i), 0, 0);
        look(32'hC);
        chk("t4_count4", 32'(count), 32'h4);
        chk("t4_st_ready", 32'(st_ready), 32'h0);
        cyc(1, 32'hC, 32'hDEAD, 0, 0);
        cyc(1, 32'h10, 32'hBEEF, 0, 0);
        look(32'hC);
        chk("t4_count_kept", 32'(count), 32'h4);
        chk("t4_no_merge_full", ld_data, 32'hC3);
        for (int i = 0; i < 4; i++) begin
            look(32'h0);
            chk("t4_drain_addr", mem_addr, 32'(4 * i));
            chk("t4_drain_data", mem_data, 32'hC0 + 32'(i));
            // A pop while full does not open st_ready in the same cycle.
            cyc(i == 0, 32'h20, 32'h99, 1, 0);
        end
        look(32'h0);
        chk("t4_empty", 32'(empty), 32'h1);

        // 5: steady push+pop at count 2 across pointer wrap
        cyc(1, 32'h300, 32'h1, 0, 0);
        cyc(1, 32'h304, 32'h2, 0, 0);
        for (int k = 0; k < 10; k++) begin
            look(32'h0);
            chk("t5_count", 32'(count), 32'h2);
            chk("t5_order", mem_addr, 32'h300 + 32'(4 * k));
            cyc(1, 32'h308 + 32'(4 * k), 32'h3 + 32'(k), 1, 0);
        end
        repeat (2) cyc(0, 0, 0, 1, 0);

        // 6: asynchronous reset mid-drain
        cyc(1, 32'h400, 32'h40, 0, 0);
        cyc(1, 32'h404, 32'h41, 0, 0);
        cyc(1, 32'h408, 32'h42, 0, 0);
        cyc(1, 32'h40C, 32'h43, 1, 0);
        st_valid  = 1'b0;
        mem_ready = 1'b0;
        ld_addr   = 32'h404;
        #2 reset = 1'b1;
        #1;
        chk("t6_mem_valid", 32'(mem_valid), 32'h0);
        chk("t6_count", 32'(count), 32'h0);
        chk("t6_ld_hit", 32'(ld_hit), 32'h0);
        chk("t6_mem_addr", mem_addr, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(1, 32'h500, 32'h55, 0, 0);
        look(32'h0);
        chk("t6_new_addr", mem_addr, 32'h500);
        chk("t6_new_data", mem_data, 32'h55);
        chk("t6_new_count", 32'(count), 32'h1);
        cyc(0, 0, 0, 1, 0);
        look(32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
